ncsp_mash_combiner: RTL and testbench
=====================================

NCSP_MASH_COMBINER -- requirements
Module: ncsp_mash_combiner

Interface
REQ-001 P_DATA_WIDTH, 8, width of integer divide word and output divide value.
REQ-002 i_clk  input  1  sole clock; all state updates on rising edge.
REQ-003 i_rst  input  1  reset; synchronous, active-high.
REQ-004 i_order  input  2  cancellation order: 1, 2 or 3; value 0 treated as 1.
REQ-005 i_int_div  input  P_DATA_WIDTH  unsigned integer part of divide ratio.
REQ-006 i_q_valid  input  1  quantizer triple present this cycle.
REQ-007 o_q_ready  output  1  combiner accepts triple this cycle.
REQ-008 i_quantize1 / i_quantize2 / i_quantize3  input  1 each  carry outputs of MASH stages 1..3.
REQ-009 o_div_valid  output  1  divide value available.
REQ-010 i_div_ready  input  1  divider consumes value this cycle.
REQ-011 o_div_value  output  P_DATA_WIDTH  saturated divide value.
REQ-012 o_frac_offset  output  4  signed noise-shaped offset belonging to o_div_value.
REQ-013 o_sat  output  1  sticky saturation flag.
REQ-014 i_sat_clr  input  1  clears o_sat.

Function
REQ-015 Input accept = i_q_valid & o_q_ready; accepts only advance history.
REQ-016 On accept: q2d<=q2, q3d<=q3, q3dd<=q3d; history updates for every order.
REQ-017 Offset: order1 = q1; order2 = q1+q2-q2d; order3 = q1+(q2-q2d)+(q3-2*q3d+q3dd); ranges [0,1], [-1,2], [-3,4].
REQ-018 Offset in 4-bit two's complement, sign-extended; no internal overflow.
REQ-019 i_order and i_int_div sampled at accept; changing i_order does not clear history.
REQ-020 Stage S1 registers offset and int_div on accept; stage S2 registers int_div+offset computed in P_DATA_WIDTH+2 signed bits.
REQ-021 S2 clamps to [0, 2^P_DATA_WIDTH-1]; o_frac_offset carries the unclamped offset.
REQ-022 S2 loads when empty or when o_div_valid & i_div_ready; S1 advances under the same rule.
REQ-023 o_q_ready = !S1_valid | S1 advancing (combinational); throughput 1 per cycle.
REQ-024 Latency: accept at cycle N -> o_div_valid at N+2 when i_div_ready held high.
REQ-025 o_div_value and o_frac_offset hold stable while o_div_valid & !i_div_ready.
REQ-026 Stall: at most 2 triples buffered; none lost, duplicated or reordered.
REQ-027 o_sat sets when a clamped value loads S2; i_sat_clr clears; simultaneous set and clear -> set wins.

Reset
REQ-028 During i_rst: o_div_valid=0, o_div_value=0, o_frac_offset=0, o_sat=0, o_q_ready=0; history and stage valids cleared.
REQ-029 Reset mid-operation discards in-flight values; nothing emitted for them.
REQ-030 o_q_ready=1 on the first cycle after i_rst deasserts.

Structure
REQ-031 Package ncsp_mash_pkg holds offset-width constant (4) and order constants ORDER1/ORDER2/ORDER3.
REQ-032 Sub-module ncsp_mash_cancel holds history registers plus cancellation network; top holds S1/S2 pipeline, saturation, handshake.

Verification
REQ-033 Order3, int_div=100, triples (q1,q2,q3) = (1,0,1),(0,0,0),(0,0,0),(0,0,0) -> offsets 2,-2,1,0; values 102,98,101,100.
REQ-034 Order2, int_div=50, q1=0, q2 = 1,0,1,0 -> values 51,49,51,49.
REQ-035 Order3, int_div=255, zero history, triple (1,1,1) -> value 255, offset 3, o_sat=1; pulse i_sat_clr -> o_sat=0.
REQ-036 Continuous valid, i_div_ready low 5 cycles:
- 2 accepts, then o_q_ready=0 and output held.
- On release, buffered values emerge in order at 1 per cycle.
REQ-037 i_rst pulsed with S1 and S2 full:
- next cycle o_div_valid=0;
- first post-reset triple (1,0,0), order3 -> offset 1.
REQ-038 Order1, int_div=10, q1 = 1,0,1 -> values 11,10,11; arrives 2 cycles after each accept.

Source files
------------

// File: rtl/ncsp_mash_pkg.sv
// Shared constants for the MASH combiner: offset width and order encodings.
package ncsp_mash_pkg;

   // Width of the signed noise-shaped offset; covers the order-3 range [-3, 4].
   localparam int unsigned OFFSET_W = 4;

   // Cancellation order selector; the zero code behaves like first order.
   typedef enum logic [1:0] {
      ORDER_DEF = 2'd0,
      ORDER1    = 2'd1,
      ORDER2    = 2'd2,
      ORDER3    = 2'd3
   } order_e;

endpackage

// File: rtl/ncsp_mash_cancel.sv
// MASH carry history and cancellation network producing the signed offset.
module ncsp_mash_cancel
   import ncsp_mash_pkg::*;
(
   input  logic                i_clk,
   input  logic                i_rst,
   input  logic                i_accept,
   input  logic [1:0]          i_order,
   input  logic                i_q1,
   input  logic                i_q2,
   input  logic                i_q3,
   output logic [OFFSET_W-1:0] o_offset
);

   logic                r_q2d;
   logic                r_q3d;
   logic                r_q3dd;
   logic [OFFSET_W-1:0] w_t1;
   logic [OFFSET_W-1:0] w_t2;
   logic [OFFSET_W-1:0] w_t3;

   // Carry history advances only on accepted triples, independent of the order.
   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         r_q2d  <= 1'b0;
         r_q3d  <= 1'b0;
         r_q3dd <= 1'b0;
      end else if (i_accept) begin
         r_q2d  <= i_q2;
         r_q3d  <= i_q3;
         r_q3dd <= r_q3d;
      end
   end

   // Differentiated carries summed in 4-bit two's complement; every order's range fits.
   always_comb begin
      w_t1 = {3'b000, i_q1};
      w_t2 = {3'b000, i_q2} - {3'b000, r_q2d};
      w_t3 = {3'b000, i_q3} - {2'b00, r_q3d, 1'b0} + {3'b000, r_q3dd};
      case (order_e'(i_order))
         ORDER2:  o_offset = w_t1 + w_t2;
         ORDER3:  o_offset = w_t1 + w_t2 + w_t3;
         default: o_offset = w_t1;
      endcase
   end

endmodule

// File: rtl/ncsp_mash_combiner.sv
// MASH 1-1-1 combiner: cancellation, two-stage pipeline, clamp and sticky saturation.
module ncsp_mash_combiner
   import ncsp_mash_pkg::*;
#(
   parameter int unsigned P_DATA_WIDTH = 8
) (
   input  logic                    i_clk,
   input  logic                    i_rst,
   input  logic [1:0]              i_order,
   input  logic [P_DATA_WIDTH-1:0] i_int_div,
   input  logic                    i_q_valid,
   output logic                    o_q_ready,
   input  logic                    i_quantize1,
   input  logic                    i_quantize2,
   input  logic                    i_quantize3,
   output logic                    o_div_valid,
   input  logic                    i_div_ready,
   output logic [P_DATA_WIDTH-1:0] o_div_value,
   output logic [OFFSET_W-1:0]     o_frac_offset,
   output logic                    o_sat,
   input  logic                    i_sat_clr
);

   localparam int unsigned SUM_W = P_DATA_WIDTH + 2;

   logic                    r_s1_valid;
   logic [OFFSET_W-1:0]     r_s1_off;
   logic [P_DATA_WIDTH-1:0] r_s1_int;
   logic                    r_s2_valid;
   logic [OFFSET_W-1:0]     r_s2_off;
   logic [P_DATA_WIDTH-1:0] r_s2_val;
   logic                    r_sat;

   logic                    w_s2_load;
   logic                    w_q_ready;
   logic                    w_accept;
   logic [OFFSET_W-1:0]     w_offset;
   logic [SUM_W-1:0]        w_off_ext;
   logic [SUM_W-1:0]        w_sum;
   logic                    w_neg;
   logic                    w_ovf;
   logic [P_DATA_WIDTH-1:0] w_clamped;

   ncsp_mash_cancel u_cancel (
      .i_clk    (i_clk),
      .i_rst    (i_rst),
      .i_accept (w_accept),
      .i_order  (i_order),
      .i_q1     (i_quantize1),
      .i_q2     (i_quantize2),
      .i_q3     (i_quantize3),
      .o_offset (w_offset)
   );

   // Handshake: S2 refills when empty or drained; S1 moves on the same condition.
   always_comb begin
      w_s2_load = !r_s2_valid | i_div_ready;
      w_q_ready = !i_rst & (!r_s1_valid | w_s2_load);
      w_accept  = i_q_valid & w_q_ready;
   end

   // Sum in two extra bits: top bit flags negative, next bit flags above full scale.
   always_comb begin
      w_off_ext = {{(SUM_W - OFFSET_W){r_s1_off[OFFSET_W-1]}}, r_s1_off};
      w_sum     = {2'b00, r_s1_int} + w_off_ext;
      w_neg     = w_sum[SUM_W-1];
      w_ovf     = !w_neg & w_sum[SUM_W-2];
      if (w_neg) begin
         w_clamped = '0;
      end else if (w_ovf) begin
         w_clamped = '1;
      end else begin
         w_clamped = w_sum[P_DATA_WIDTH-1:0];
      end
   end

   // Stage S1 captures the offset and integer word of each accepted triple.
   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         r_s1_valid <= 1'b0;
         r_s1_off   <= '0;
         r_s1_int   <= '0;
      end else if (w_s2_load | !r_s1_valid) begin
         r_s1_valid <= w_accept;
         if (w_accept) begin
            r_s1_off <= w_offset;
            r_s1_int <= i_int_div;
         end
      end
   end

   // Stage S2 holds the clamped divide value and its unclamped offset.
   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         r_s2_valid <= 1'b0;
         r_s2_off   <= '0;
         r_s2_val   <= '0;
      end else if (w_s2_load) begin
         r_s2_valid <= r_s1_valid;
         if (r_s1_valid) begin
            r_s2_off <= r_s1_off;
            r_s2_val <= w_clamped;
         end
      end
   end

   // Sticky saturation; a clamp loading S2 takes priority over a clear.
   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         r_sat <= 1'b0;
      end else if (w_s2_load & r_s1_valid & (w_neg | w_ovf)) begin
         r_sat <= 1'b1;
      end else if (i_sat_clr) begin
         r_sat <= 1'b0;
      end
   end

   // Outputs forced to their idle values for as long as reset is held.
   always_comb begin
      o_q_ready     = w_q_ready;
      o_div_valid   = r_s2_valid & !i_rst;
      o_div_value   = i_rst ? '0 : r_s2_val;
      o_frac_offset = i_rst ? '0 : r_s2_off;
      o_sat         = r_sat & !i_rst;
   end

endmodule

// File: tb/tb_ncsp_mash_combiner.sv
// Directed bench for ncsp_mash_combiner with hand-computed expectations.
module tb_ncsp_mash_combiner;

   logic       clk = 1'b0;
   logic       rst;
   logic [1:0] order;
   logic [7:0] int_div;
   logic       q_valid;
   logic       q_ready;
   logic       q1, q2, q3;
   logic       div_valid;
   logic       div_ready;
   logic [7:0] div_value;
   logic [3:0] frac_offset;
   logic       sat;
   logic       sat_clr;

   int errors = 0;
   int checks = 0;

   always #5 clk = ~clk;

   ncsp_mash_combiner #(.P_DATA_WIDTH(8)) dut (
      .i_clk         (clk),
      .i_rst         (rst),
      .i_order       (order),
      .i_int_div     (int_div),
      .i_q_valid     (q_valid),
      .o_q_ready     (q_ready),
      .i_quantize1   (q1),
      .i_quantize2   (q2),
      .i_quantize3   (q3),
      .o_div_valid   (div_valid),
      .i_div_ready   (div_ready),
      .o_div_value   (div_value),
      .o_frac_offset (frac_offset),
      .o_sat         (sat),
      .i_sat_clr     (sat_clr)
   );

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Present one triple for a single edge; ready must be high beforehand.
   task automatic send(input logic [1:0] o, input logic [7:0] d,
                       input logic a, input logic b, input logic c);
      order   = o;
      int_div = d;
      q1      = a;
      q2      = b;
      q3      = c;
      q_valid = 1'b1;
      #1;
      chk("send_ready", {15'd0, q_ready}, 16'd1);
      tick();
      q_valid = 1'b0;
      q1 = 1'b0; q2 = 1'b0; q3 = 1'b0;
      #1;
   endtask

   // Send, confirm nothing after one edge, then the value after the second.
   task automatic xfer(input string tag, input logic [1:0] o, input logic [7:0] d,
                       input logic a, input logic b, input logic c,
                       input logic [7:0] ev, input logic [3:0] eo);
      send(o, d, a, b, c);
      chk({tag, "_early"}, {15'd0, div_valid}, 16'd0);
      tick();
      chk({tag, "_valid"}, {15'd0, div_valid}, 16'd1);
      chk({tag, "_value"}, {8'd0, div_value}, {8'd0, ev});
      chk({tag, "_off"},   {12'd0, frac_offset}, {12'd0, eo});
   endtask

   task automatic do_reset();
      rst = 1'b1;
      q_valid = 1'b0;
      tick();
      tick();
      rst = 1'b0;
      #1;
   endtask

   initial begin
      rst = 1'b1; order = 2'd1; int_div = 8'd0; q_valid = 1'b0;
      q1 = 1'b0; q2 = 1'b0; q3 = 1'b0; div_ready = 1'b1; sat_clr = 1'b0;
      tick();
      tick();
      chk("rst_valid", {15'd0, div_valid}, 16'd0);
      chk("rst_value", {8'd0, div_value}, 16'd0);
      chk("rst_off",   {12'd0, frac_offset}, 16'd0);
      chk("rst_sat",   {15'd0, sat}, 16'd0);
      chk("rst_ready", {15'd0, q_ready}, 16'd0);
      rst = 1'b0;
      #1;
      chk("post_rst_ready", {15'd0, q_ready}, 16'd1);

      // Order 3 history sequence.
      xfer("o3a", 2'd3, 8'd100, 1'b1, 1'b0, 1'b1, 8'd102, 4'h2);
      xfer("o3b", 2'd3, 8'd100, 1'b0, 1'b0, 1'b0, 8'd98,  4'he);
      xfer("o3c", 2'd3, 8'd100, 1'b0, 1'b0, 1'b0, 8'd101, 4'h1);
      xfer("o3d", 2'd3, 8'd100, 1'b0, 1'b0, 1'b0, 8'd100, 4'h0);

      // Order 2 alternating second-stage carry.
      xfer("o2a", 2'd2, 8'd50, 1'b0, 1'b1, 1'b0, 8'd51, 4'h1);
      xfer("o2b", 2'd2, 8'd50, 1'b0, 1'b0, 1'b0, 8'd49, 4'hf);
      xfer("o2c", 2'd2, 8'd50, 1'b0, 1'b1, 1'b0, 8'd51, 4'h1);
      xfer("o2d", 2'd2, 8'd50, 1'b0, 1'b0, 1'b0, 8'd49, 4'hf);

      // Order 1, then order code 0 behaving as order 1.
      xfer("o1a", 2'd1, 8'd10, 1'b1, 1'b0, 1'b0, 8'd11, 4'h1);
      xfer("o1b", 2'd1, 8'd10, 1'b0, 1'b0, 1'b0, 8'd10, 4'h0);
      xfer("o1c", 2'd1, 8'd10, 1'b1, 1'b0, 1'b0, 8'd11, 4'h1);
      xfer("o0",  2'd0, 8'd10, 1'b1, 1'b1, 1'b1, 8'd11, 4'h1);

      // Upper clamp with sticky flag and clear.
      do_reset();
      xfer("sat_hi", 2'd3, 8'd255, 1'b1, 1'b1, 1'b1, 8'd255, 4'h3);
      chk("sat_set", {15'd0, sat}, 16'd1);
      tick();
      chk("sat_sticky", {15'd0, sat}, 16'd1);
      sat_clr = 1'b1;
      tick();
      sat_clr = 1'b0;
      chk("sat_clr", {15'd0, sat}, 16'd0);

      // Lower clamp: offset -3 on zero integer word.
      do_reset();
      xfer("lo_a", 2'd3, 8'd0, 1'b0, 1'b1, 1'b1, 8'd2, 4'h2);
      chk("lo_nosat", {15'd0, sat}, 16'd0);
      xfer("lo_b", 2'd3, 8'd0, 1'b0, 1'b0, 1'b0, 8'd0, 4'hd);
      chk("lo_sat", {15'd0, sat}, 16'd1);
      sat_clr = 1'b1;
      tick();
      sat_clr = 1'b0;
      chk("lo_clr", {15'd0, sat}, 16'd0);

      // Clear coincident with a clamped load: set wins.
      send(2'd3, 8'd255, 1'b1, 1'b0, 1'b0);
      sat_clr = 1'b1;
      tick();
      sat_clr = 1'b0;
      chk("setwin_sat",   {15'd0, sat}, 16'd1);
      chk("setwin_value", {8'd0, div_value}, 16'd255);
      chk("setwin_off",   {12'd0, frac_offset}, 16'd2);
      sat_clr = 1'b1;
      tick();
      sat_clr = 1'b0;

      // Back-pressure: two triples buffer, then drain in order.
      order = 2'd1; q1 = 1'b0; q2 = 1'b0; q3 = 1'b0;
      div_ready = 1'b0;
      int_div = 8'd10; q_valid = 1'b1;
      #1;
      chk("stall_rdy0", {15'd0, q_ready}, 16'd1);
      tick();
      int_div = 8'd20;
      #1;
      chk("stall_rdy1", {15'd0, q_ready}, 16'd1);
      tick();
      int_div = 8'd30;
      #1;
      chk("stall_full", {15'd0, q_ready}, 16'd0);
      chk("stall_valid", {15'd0, div_valid}, 16'd1);
      chk("stall_val", {8'd0, div_value}, 16'd10);
      for (int k = 0; k < 3; k++) begin
         tick();
         chk("stall_hold_rdy", {15'd0, q_ready}, 16'd0);
         chk("stall_hold_val", {8'd0, div_value}, 16'd10);
      end
      div_ready = 1'b1;
      #1;
      chk("release_rdy", {15'd0, q_ready}, 16'd1);
      tick();
      q_valid = 1'b0;
      #1;
      chk("drain_b_valid", {15'd0, div_valid}, 16'd1);
      chk("drain_b", {8'd0, div_value}, 16'd20);
      tick();
      chk("drain_c_valid", {15'd0, div_valid}, 16'd1);
      chk("drain_c", {8'd0, div_value}, 16'd30);
      tick();
      chk("drain_empty", {15'd0, div_valid}, 16'd0);

      // Reset with both stages full discards everything, history included.
      div_ready = 1'b0;
      send(2'd3, 8'd60, 1'b0, 1'b1, 1'b1);
      send(2'd3, 8'd70, 1'b0, 1'b0, 1'b1);
      chk("full_rdy", {15'd0, q_ready}, 16'd0);
      chk("full_val", {8'd0, div_value}, 16'd62);
      rst = 1'b1;
      #1;
      chk("midrst_valid", {15'd0, div_valid}, 16'd0);
      chk("midrst_rdy", {15'd0, q_ready}, 16'd0);
      tick();
      rst = 1'b0;
      div_ready = 1'b1;
      #1;
      chk("after_rst_valid", {15'd0, div_valid}, 16'd0);
      chk("after_rst_rdy", {15'd0, q_ready}, 16'd1);
      tick();
      chk("no_ghost1", {15'd0, div_valid}, 16'd0);
      tick();
      chk("no_ghost2", {15'd0, div_valid}, 16'd0);
      xfer("post_rst", 2'd3, 8'd40, 1'b1, 1'b0, 1'b0, 8'd41, 4'h1);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
